// File: rtl/urna_pkg.sv
// Shared types and constants for the urna keypad front-end.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package urna_pkg;

  // Keypad handler states
  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // What an accepted key turns into on the urna side
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_DIGIT  = 2'd1,
    CLS_FINISH = 2'd2,
    CLS_CLEAR  = 2'd3
  } key_class_t;

  localparam logic [3:0] KEY_CONFIRMA = 4'hA;
  localparam logic [3:0] KEY_CORRIGE  = 4'hB;
  localparam logic [3:0] KEY_NONE     = 4'hF;
  localparam logic [3:0] ROW_IDLE     = 4'b1111;

  // Physical (row, col) position to key code; C, *, # and D have no function
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = KEY_CONFIRMA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = KEY_CORRIGE;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd13:   code = 4'h0;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Key code to its output class
  function automatic key_class_t class_of(input logic [3:0] code);
    key_class_t cls;
    if (code == KEY_CONFIRMA)     cls = CLS_FINISH;
    else if (code == KEY_CORRIGE) cls = CLS_CLEAR;
    else if (code <= 4'd9)        cls = CLS_DIGIT;
    else                          cls = CLS_NONE;
    return cls;
  endfunction

  // Active-low one-hot column drive for a column index
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the 4 asynchronous keypad row lines; resets to idle (all ones).
// Latency: 2 cycles.
// Backpressure: none.
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_urna.sv
// 4x4 keypad front-end: column scan, row sync, press/release debounce, Digit/Valid/Finish/Clear strobes.
// Latency: DEBOUNCE_CYCLES+2 cycles from the scan sample that sees a key to the rise of its strobe.
// Backpressure: none; one key at a time, all keys must be released before the next is accepted.
// Optional: define TECLADO_ECHO_EN to add the Echo[15:0] display register of the current vote.
module teclado_urna
  import urna_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int VALID_CYCLES    = 2,
  parameter int MAX_DIGITS      = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Row,
  output logic [3:0]  Col,
  output logic [3:0]  Digit,
  output logic        Valid,
  output logic        Finish,
  output logic        Clear,
  output logic [2:0]  DigitCount
`ifdef TECLADO_ECHO_EN
  ,
  output logic [15:0] Echo
`endif
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(VALID_CYCLES + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] VALID_LEN = HW'(VALID_CYCLES);
  localparam logic [2:0]    MAX_CNT   = 3'(MAX_DIGITS);

  logic [3:0]    row_s;
  state_t        state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [1:0]    low_row;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] strobe_len;
  logic [3:0]    row_pat;
  logic [3:0]    key;
  key_class_t    key_cls;
  key_class_t    emit_cls;
  logic          emit_digit;
  logic          emit_wipe;
  // A key held through reset must not be taken as a new press: scanning
  // stays disarmed until every column has been sampled idle in a row.
  logic          armed;
  logic [1:0]    idle_wins;

  sync_2ff u_sync (
    .clk   (Clock),
    .rst_n (Reset),
    .d     (Row),
    .q     (row_s)
  );

  // Lowest-numbered row currently pulled low
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row = 2'(i);
    end
  end

  // Decode the latched key and decide what the EMIT cycle does with it
  always_comb begin
    key        = key_code(row_idx, col_idx);
    emit_cls   = class_of(key);
    emit_digit = (state == EMIT) && (emit_cls == CLS_DIGIT) && (DigitCount < MAX_CNT);
    emit_wipe  = (state == EMIT) && ((emit_cls == CLS_FINISH) || (emit_cls == CLS_CLEAR));
  end

  // Strobe length for the class accepted at EMIT (zero for ignored keys)
  always_comb begin
    case (key_cls)
      CLS_DIGIT:             strobe_len = VALID_LEN;
      CLS_FINISH, CLS_CLEAR: strobe_len = HW'(1);
      default:               strobe_len = '0;
    endcase
  end

  // Scan / debounce / emit / hold / release sequencer with registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= SCAN;
      Col        <= 4'b1110;
      col_idx    <= 2'd0;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      row_pat    <= ROW_IDLE;
      row_idx    <= 2'd0;
      key_cls    <= CLS_NONE;
      armed      <= 1'b0;
      idle_wins  <= 2'd0;
      Digit      <= 4'h0;
      Valid      <= 1'b0;
      Finish     <= 1'b0;
      Clear      <= 1'b0;
      DigitCount <= 3'd0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (armed && (row_s != ROW_IDLE)) begin
              // Freeze Col on this column and remember what was seen
              row_pat <= row_s;
              row_idx <= low_row;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              Col     <= col_drive(col_idx + 2'd1);
              if (!armed) begin
                if (row_s != ROW_IDLE) idle_wins <= 2'd0;
                else if (idle_wins == 2'd3) armed <= 1'b1;
                else idle_wins <= idle_wins + 2'd1;
              end
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end

        DEBOUNCE: begin
          if (row_s != row_pat) begin
            // Bounce: abandon this key and carry on from the next column
            state    <= SCAN;
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            Col      <= col_drive(col_idx + 2'd1);
          end else if (deb_cnt == DEB_LAST) begin
            state <= EMIT;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        EMIT: begin
          hold_cnt <= '0;
          state    <= HOLD;
          if (emit_digit) begin
            Digit      <= key;
            DigitCount <= DigitCount + 3'd1;
            key_cls    <= CLS_DIGIT;
          end else if (emit_wipe) begin
            DigitCount <= 3'd0;
            key_cls    <= emit_cls;
          end else begin
            key_cls    <= CLS_NONE;
          end
        end

        HOLD: begin
          if (hold_cnt < strobe_len) begin
            hold_cnt <= hold_cnt + HW'(1);
            Valid    <= (key_cls == CLS_DIGIT);
            Finish   <= (key_cls == CLS_FINISH);
            Clear    <= (key_cls == CLS_CLEAR);
          end else begin
            Valid   <= 1'b0;
            Finish  <= 1'b0;
            Clear   <= 1'b0;
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          // Col stays frozen; any low row restarts the idle count
          if (row_s != ROW_IDLE) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= SCAN;
            scan_cnt <= '0;
            col_idx  <= 2'd0;
            Col      <= col_drive(2'd0);
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

`ifdef TECLADO_ECHO_EN
  // Display register of the current vote, newest digit in the low nibble
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)          Echo <= 16'h0000;
    else if (emit_wipe)  Echo <= 16'h0000;
    else if (emit_digit) Echo <= {Echo[11:0], key};
  end
`endif

endmodule

// File: tb/tb_teclado_urna.sv
// Bench for teclado_urna: keypad model driven by Col, strobe monitor, and a key-level vote model.
module tb_teclado_urna;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] Digit;
  logic       Valid;
  logic       Finish;
  logic       Clear;
  logic [2:0] DigitCount;
`ifdef TECLADO_ECHO_EN
  logic [15:0] Echo;
`endif

  int checks   = 0;
  int failures = 0;

  // Pressed keys, index = row*4 + col
  logic [15:0] keys = 16'h0000;
  string keymap = "123A456B789C*0#D";

  // Strobe events seen by the monitor
  int ev_kind  [256];
  int ev_digit [256];
  int ev_cnt   [256];
  int ev_width [256];
  int ev_time  [256];
  int ev_wr     = 0;
  int ev_rd     = 0;
  int cyc       = 0;
  int excl_viol = 0;
  int unstable  = 0;

  // Vote model state
  int          ref_count = 0;
  int          ref_digit = 0;
  logic [15:0] ref_echo  = 16'h0000;

  teclado_urna dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Row        (Row),
    .Col        (Col),
    .Digit      (Digit),
    .Valid      (Valid),
    .Finish     (Finish),
    .Clear      (Clear),
    .DigitCount (DigitCount)
`ifdef TECLADO_ECHO_EN
    ,
    .Echo       (Echo)
`endif
  );

  always #5 Clock = ~Clock;

  // Matrix keypad: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    Row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Col[c]) Row[r] = 1'b0;
  end

  // Strobe monitor: records each pulse (kind, digit, count at rise, width, rise time)
  initial begin
    logic pv, pf, pc;
    logic [3:0] pdig;
    int vw, vd, vc, vt, fw, fc, ft, cw, cc, ct;
    pv = 0; pf = 0; pc = 0; pdig = 0;
    vw = 0; vd = 0; vc = 0; vt = 0; fw = 0; fc = 0; ft = 0; cw = 0; cc = 0; ct = 0;
    forever begin
      @(negedge Clock);
      cyc++;
      if (int'(Valid) + int'(Finish) + int'(Clear) > 1) excl_viol++;
      if (Valid && !pv) begin
        vw = 0; vd = int'(Digit); vc = int'(DigitCount); vt = cyc;
        if (Digit !== pdig) unstable++;
      end
      if (Valid) begin
        vw++;
        if (int'(Digit) != vd) unstable++;
      end
      if (!Valid && pv) begin
        ev_kind[ev_wr%256] = 1; ev_digit[ev_wr%256] = vd; ev_cnt[ev_wr%256] = vc;
        ev_width[ev_wr%256] = vw; ev_time[ev_wr%256] = vt; ev_wr++;
      end
      if (Finish && !pf) begin fw = 0; fc = int'(DigitCount); ft = cyc; end
      if (Finish) fw++;
      if (!Finish && pf) begin
        ev_kind[ev_wr%256] = 2; ev_digit[ev_wr%256] = 0; ev_cnt[ev_wr%256] = fc;
        ev_width[ev_wr%256] = fw; ev_time[ev_wr%256] = ft; ev_wr++;
      end
      if (Clear && !pc) begin cw = 0; cc = int'(DigitCount); ct = cyc; end
      if (Clear) cw++;
      if (!Clear && pc) begin
        ev_kind[ev_wr%256] = 3; ev_digit[ev_wr%256] = 0; ev_cnt[ev_wr%256] = cc;
        ev_width[ev_wr%256] = cw; ev_time[ev_wr%256] = ct; ev_wr++;
      end
      pv = Valid; pf = Finish; pc = Clear; pdig = Digit;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic press_key(input int k, input int hold, input int gap);
    keys[k] = 1'b1;
    tick(hold);
    keys[k] = 1'b0;
    tick(gap);
  endtask

  // Pulls the events seen since the last call; returns the count and the first one
  task automatic fetch_events(output int n, output int kind, output int digit,
                              output int cnt, output int width, output int t);
    n = ev_wr - ev_rd;
    kind = 0; digit = 0; cnt = 0; width = 0; t = 0;
    if (n > 0) begin
      kind  = ev_kind[ev_rd%256];
      digit = ev_digit[ev_rd%256];
      cnt   = ev_cnt[ev_rd%256];
      width = ev_width[ev_rd%256];
      t     = ev_time[ev_rd%256];
    end
    ev_rd = ev_wr;
  endtask

  // Vote model: what one clean press of key k should produce (kind 0 = no strobe)
  task automatic model_press(input int k, output int kind, output int digit,
                             output int cnt, output int width);
    byte ch;
    ch = keymap[k];
    kind = 0; width = 0;
    if (ch >= 8'd48 && ch <= 8'd57) begin          // '0'..'9'
      if (ref_count < 4) begin
        ref_count++;
        ref_digit = int'(ch) - 48;
        ref_echo  = {ref_echo[11:0], 4'(ref_digit)};
        kind = 1; width = 2;
      end
    end else if (ch == 8'd65) begin                 // 'A' Confirma
      ref_count = 0; ref_echo = 16'h0000; kind = 2; width = 1;
    end else if (ch == 8'd66) begin                 // 'B' Corrige
      ref_count = 0; ref_echo = 16'h0000; kind = 3; width = 1;
    end
    digit = ref_digit;
    cnt   = ref_count;
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (Col !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", Col); end
    checks++; if (Digit !== 4'h0) begin failures++; $display("FAIL reset_digit got=%h exp=0", Digit); end
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++; if (Finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", Finish); end
    checks++; if (Clear !== 1'b0) begin failures++; $display("FAIL reset_clear got=%b exp=0", Clear); end
    checks++; if (DigitCount !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", DigitCount); end
    Reset = 1'b1;
    ref_count = 0; ref_digit = 0; ref_echo = 16'h0000;
    tick(40);
  endtask

  // Key 3 (r0,c2): strobe 10 cycles after the scan sample, which is the 4th edge of the c2 window
  task automatic test_latency;
    int g, n, kind, digit, cnt, width, t, ek, ed, ec, ew;
    g = 0;
    while (Col == 4'b1011 && g < 40) begin tick(1); g++; end
    keys[2] = 1'b1;
    g = 0;
    while (Col != 4'b1011 && g < 40) begin tick(1); g++; end
    checks++; if (g >= 40) begin failures++; $display("FAIL latency_colwait got=timeout exp=col2 driven"); end
    n = 0;
    while (!Valid && n < 60) begin tick(1); n++; end
    checks++; if (n != 14) begin failures++; $display("FAIL latency got=%0d exp=14 cycles from col2 drive", n); end
    tick(26);
    keys[2] = 1'b0;
    tick(30);
    model_press(2, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++; if (n != 1) begin failures++; $display("FAIL key3_pulses got=%0d exp=1", n); end
    checks++;
    if (kind != ek || digit != ed || cnt != ec || width != ew) begin
      failures++;
      $display("FAIL key3_event got=k%0d d%0d c%0d w%0d exp=k%0d d%0d c%0d w%0d", kind, digit, cnt, width, ek, ed, ec, ew);
    end
  endtask

  // Key 5 bounces every 2 cycles for 10 cycles, then settles
  task automatic test_bounce;
    int bend, n, kind, digit, cnt, width, t, ek, ed, ec, ew;
    for (int i = 0; i < 5; i++) begin
      keys[5] = (i % 2 == 0);
      tick(2);
    end
    keys[5] = 1'b1;
    bend = cyc;
    tick(40);
    keys[5] = 1'b0;
    tick(30);
    model_press(5, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++; if (n != 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", n); end
    checks++;
    if (kind != ek || digit != ed || cnt != ec || width != ew) begin
      failures++;
      $display("FAIL bounce_event got=k%0d d%0d c%0d w%0d exp=k%0d d%0d c%0d w%0d", kind, digit, cnt, width, ek, ed, ec, ew);
    end
    checks++; if (t <= bend) begin failures++; $display("FAIL bounce_timing got=rise@%0d exp=after %0d", t, bend); end
  endtask

  // B to start clean, then 3,4,9,4 and Confirma
  task automatic test_vote_sequence;
    int seq[6] = '{7, 2, 4, 10, 4, 3};
    int n, kind, digit, cnt, width, t, ek, ed, ec, ew;
    for (int i = 0; i < 6; i++) begin
      press_key(seq[i], 50, 30);
      model_press(seq[i], ek, ed, ec, ew);
      fetch_events(n, kind, digit, cnt, width, t);
      checks++;
      if (n != 1 || kind != ek || (ek == 1 && digit != ed) || cnt != ec || width != ew) begin
        failures++;
        $display("FAIL vote_step%0d got=n%0d k%0d d%0d c%0d w%0d exp=n1 k%0d d%0d c%0d w%0d", i, n, kind, digit, cnt, width, ek, ed, ec, ew);
      end
    end
    checks++; if (DigitCount !== 3'd0) begin failures++; $display("FAIL vote_count_after_finish got=%0d exp=0", DigitCount); end
  endtask

  // Fifth digit ignored, then Corrige
  task automatic test_fifth_digit;
    int seq[5] = '{2, 4, 10, 4, 8};
    int n, kind, digit, cnt, width, t, ek, ed, ec, ew, en;
    for (int i = 0; i < 5; i++) begin
      press_key(seq[i], 50, 30);
      model_press(seq[i], ek, ed, ec, ew);
      fetch_events(n, kind, digit, cnt, width, t);
      en = (ek != 0) ? 1 : 0;
      checks++;
      if (n != en || (en == 1 && (kind != ek || digit != ed || cnt != ec || width != ew))) begin
        failures++;
        $display("FAIL fifth_step%0d got=n%0d k%0d d%0d c%0d w%0d exp=n%0d k%0d d%0d c%0d w%0d", i, n, kind, digit, cnt, width, en, ek, ed, ec, ew);
      end
    end
    checks++; if (int'(Digit) != ref_digit) begin failures++; $display("FAIL fifth_digit_held got=%0d exp=%0d", Digit, ref_digit); end
    checks++; if (int'(DigitCount) != ref_count) begin failures++; $display("FAIL fifth_count got=%0d exp=%0d", DigitCount, ref_count); end
    press_key(7, 50, 30);
    model_press(7, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++;
    if (n != 1 || kind != ek || width != ew || cnt != ec) begin
      failures++;
      $display("FAIL corrige got=n%0d k%0d c%0d w%0d exp=n1 k%0d c%0d w%0d", n, kind, cnt, width, ek, ec, ew);
    end
  endtask

  // 5 and 9 pressed together while column 0 is driven, then D
  task automatic test_multi_key;
    int g, n, kind, digit, cnt, width, t, ek, ed, ec, ew;
    g = 0;
    while (Col != 4'b1110 && g < 40) begin tick(1); g++; end
    keys[5] = 1'b1; keys[10] = 1'b1;
    tick(60);
    keys[5] = 1'b0; keys[10] = 1'b0;
    tick(30);
    model_press(5, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++;
    if (n != 1 || kind != ek || digit != ed || cnt != ec) begin
      failures++;
      $display("FAIL multi_key got=n%0d k%0d d%0d c%0d exp=n1 k%0d d%0d c%0d", n, kind, digit, cnt, ek, ed, ec);
    end
    press_key(15, 50, 30);
    model_press(15, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++; if (n != 0) begin failures++; $display("FAIL key_d_strobe got=%0d pulses exp=0", n); end
    checks++; if (int'(DigitCount) != ref_count) begin failures++; $display("FAIL key_d_count got=%0d exp=%0d", DigitCount, ref_count); end
  endtask

  // Reset during the Valid pulse of 8, key kept held afterwards
  task automatic test_reset_mid_hold;
    int g, n, kind, digit, cnt, width, t, ek, ed, ec, ew;
    keys[9] = 1'b1;
    g = 0;
    while (!Valid && g < 80) begin tick(1); g++; end
    checks++; if (g >= 80) begin failures++; $display("FAIL rst_hold_valid got=timeout exp=Valid for key 8"); end
    Reset = 1'b0;
    #1;
    checks++;
    if (Valid !== 1'b0 || Col !== 4'b1110 || Digit !== 4'h0 || DigitCount !== 3'd0 || Finish !== 1'b0 || Clear !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_hold got=V%b Col%b D%h C%0d F%b K%b exp=V0 Col1110 D0 C0 F0 K0", Valid, Col, Digit, DigitCount, Finish, Clear);
    end
    tick(3);
    Reset = 1'b1;
    tick(2);
    fetch_events(n, kind, digit, cnt, width, t);
    ref_count = 0; ref_digit = 0; ref_echo = 16'h0000;
    tick(100);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++; if (n != 0) begin failures++; $display("FAIL rst_held_key got=%0d pulses exp=0", n); end
    keys[9] = 1'b0;
    tick(40);
    press_key(9, 50, 30);
    model_press(9, ek, ed, ec, ew);
    fetch_events(n, kind, digit, cnt, width, t);
    checks++;
    if (n != 1 || kind != ek || digit != ed || cnt != ec || width != ew) begin
      failures++;
      $display("FAIL rst_repress got=n%0d k%0d d%0d c%0d w%0d exp=n1 k%0d d%0d c%0d w%0d", n, kind, digit, cnt, width, ek, ed, ec, ew);
    end
  endtask

  // Random keys, hold and gap times against the vote model
  task automatic test_random;
    int k, n, kind, digit, cnt, width, t, ek, ed, ec, ew, en;
    for (int i = 0; i < 14; i++) begin
      k = int'($urandom_range(0, 15));
      press_key(k, int'($urandom_range(45, 70)), int'($urandom_range(25, 40)));
      model_press(k, ek, ed, ec, ew);
      fetch_events(n, kind, digit, cnt, width, t);
      en = (ek != 0) ? 1 : 0;
      checks++;
      if (n != en || (en == 1 && (kind != ek || (ek == 1 && digit != ed) || cnt != ec || width != ew))) begin
        failures++;
        $display("FAIL rand%0d key%0d got=n%0d k%0d d%0d c%0d w%0d exp=n%0d k%0d d%0d c%0d w%0d", i, k, n, kind, digit, cnt, width, en, ek, ed, ec, ew);
      end
      checks++; if (int'(DigitCount) != ref_count) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", i, DigitCount, ref_count); end
`ifdef TECLADO_ECHO_EN
      checks++; if (Echo !== ref_echo) begin failures++; $display("FAIL rand%0d_echo got=%h exp=%h", i, Echo, ref_echo); end
`endif
    end
  endtask

  task automatic test_invariants;
    checks++; if (excl_viol != 0) begin failures++; $display("FAIL strobe_exclusive got=%0d overlaps exp=0", excl_viol); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL digit_stable got=%0d changes exp=0", unstable); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_bounce;
    test_vote_sequence;
    test_fifth_digit;
    test_multi_key;
    test_reset_mid_hold;
    test_random;
    test_invariants;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/teclado_urna.md
Name: teclado_urna

Overview:
- Keypad front-end for Urna_module: scans a 4x4 matrix keypad, synchronises and debounces it, and produces the Digit/Valid/Finish stimulus the urna consumes.
- Replaces bench-driven digit entry with the physical voter interface.
- Sits directly upstream of Urna_module, sharing its Clock.

Parameters:
- SCAN_DIV, 4: cycles each column is driven before Row is sampled; minimum 3.
- DEBOUNCE_CYCLES, 8: consecutive stable samples needed to accept a press or a release.
- VALID_CYCLES, 2: width of the Valid pulse per accepted digit.
- MAX_DIGITS, 4: digit keys accepted per vote before Confirma/Corrige.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Row  in  4  keypad rows, active-low, pulled up externally, asynchronous to Clock.
- Col  out  4  column drive, active-low one-hot.
- Digit  out  4  BCD digit handed to urna.
- Valid  out  1  digit strobe.
- Finish  out  1  Confirma strobe, 1 cycle.
- Clear  out  1  Corrige strobe, 1 cycle.
- DigitCount  out  3  digits accepted in the current vote, 0..MAX_DIGITS.

Behaviour:
- Reset (Reset=0, asynchronous) values: Col=4'b1110, Digit=0, Valid=0, Finish=0, Clear=0, DigitCount=0, state SCAN, sync flops=4'b1111, counters=0. Reset mid-press aborts everything with no strobe; the key must be released and pressed again.
- Row passes through a 2-flop synchroniser; all logic uses the synced value RowS.
- Key map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A = Confirma, B = Corrige. C, *, # and D are debounced but produce no output.
- FSM states: SCAN, DEBOUNCE, EMIT, HOLD, RELEASE.
- SCAN:
  - Column index advances 0->1->2->3->0 every SCAN_DIV cycles.
  - On the last cycle of each window, RowS is sampled. If RowS!=4'b1111, latch column index and lowest-numbered low row, then go to DEBOUNCE with Col frozen.
- DEBOUNCE:
  - Each cycle RowS must equal the latched pattern. Mismatch returns to SCAN, resuming at the next column.
  - DEBOUNCE_CYCLES matches go to EMIT.
- EMIT (1 cycle), by key class:
  - Digit with DigitCount<MAX_DIGITS: Digit<=code; DigitCount++.
  - Digit with DigitCount==MAX_DIGITS: ignored.
  - Confirma: DigitCount<=0 (Finish emitted even when the count is 0).
  - Corrige: DigitCount<=0.
  - Then go to HOLD.
- HOLD:
  - The cycle after EMIT, the strobe for the accepted key class rises.
  - Valid stays high for VALID_CYCLES; Finish or Clear for 1 cycle.
  - Digit is stable 1 cycle before Valid rises and held until the next accepted digit.
  - Go to RELEASE when the strobe ends.
- RELEASE:
  - Col stays frozen; needs RowS==4'b1111 for DEBOUNCE_CYCLES consecutive cycles, and any low row restarts the count.
  - Then go to SCAN at column 0.
  - Extra keys pressed while a key is held are ignored until all keys are released.
- Valid, Finish and Clear are mutually exclusive; at most one is high in any cycle.
- Latency from first stable RowS sample to strobe: DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
- Macro TECLADO_ECHO_EN.
- Defined:
  - Adds output Echo[15:0], the digits of the current vote for a display, newest in [3:0].
  - Each accepted digit shifts left by 4.
  - Finish or Clear (the EMIT cycle) zeroes Echo.
  - Reset value 0.
- Undefined: Echo port and its register are absent; all other behaviour is identical.

Decomposition:
- Package urna_pkg holds:
  - state enum (SCAN, DEBOUNCE, EMIT, HOLD, RELEASE).
  - key-code constants: KEY_CONFIRMA=4'hA, KEY_CORRIGE=4'hB, KEY_NONE.
  - the 16-entry row/col-to-code map function.
  - ROW_IDLE=4'b1111.
- One sub-module, sync_2ff: 4-bit two-flop synchroniser with asynchronous active-low reset to 1s.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8, VALID_CYCLES=2):
- Press key 3 (r0,c2) clean for 40 cycles, then release:
  - Digit=4'h3, Valid high exactly 2 cycles, DigitCount=1.
  - Strobe rises 10 cycles after the first stable RowS; no second pulse.
- Bounce on press (Row toggles every 2 cycles for 10 cycles, then stable):
  - exactly one Valid pulse for that key, after it stabilises.
- Vote sequence 3,4,9,4 then A:
  - four Valid pulses with Digits 3,4,9,4; DigitCount 1..4.
  - Finish a single cycle; DigitCount=0 after it.
- Fifth digit 7 after four digits:
  - no Valid, Digit stays 4 and DigitCount stays 4.
  - then B gives a 1-cycle Clear and DigitCount=0.
- Keys 5 and 9 held together, then D:
  - only 5 emitted; 9 ignored until all released.
  - D produces no strobe.
- Reset pulled low during HOLD of digit 8:
  - Valid drops immediately; outputs at reset values.
  - No strobe while 8 stays held after reset.
  - A new press of 8 is accepted normally.
